// File: rtl/data_cache_pkg.sv
// data_cache shared types: controller state and the fixed
// address / block geometry of the 8-bit CPU port.
package data_cache_pkg;

  localparam int BLOCK_BYTES = 4;
  localparam int ADDR_W      = 8;
  localparam int MEM_ADDR_W  = 6;
  localparam int BLOCK_W     = BLOCK_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    MEM_READ   = 2'd2
  } state_t;

endpackage

// File: rtl/data_cache_fsm.sv
// data_cache miss controller: IDLE / WRITE_BACK / MEM_READ.
// In: clk, rst, read, write, hit, line_dirty, mem_busywait.
// Out: state, busywait, mem_read, mem_write, fill (load line),
//      miss (one cycle per IDLE miss transition).
module data_cache_fsm
  import data_cache_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   read,
  input  logic   write,
  input  logic   hit,
  input  logic   line_dirty,
  input  logic   mem_busywait,
  output state_t state,
  output logic   busywait,
  output logic   mem_read,
  output logic   mem_write,
  output logic   fill,
  output logic   miss
);

  state_t next;
  logic   entry_q;
  logic   entry_d;
  logic   req;
  logic   done;

  assign req = read | write;
  // memory may still show the previous transfer's busywait
  // during the entry cycle, so that edge is never taken as done
  assign done = !entry_q && !mem_busywait;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      entry_q <= 1'b0;
    end else begin
      state   <= next;
      entry_q <= entry_d;
    end
  end

  always_comb begin
    next      = state;
    entry_d   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    fill      = 1'b0;
    miss      = 1'b0;
    busywait  = req && !(state == IDLE && hit);
    unique case (state)
      IDLE: begin
        if (req && !hit) begin
          miss    = 1'b1;
          entry_d = 1'b1;
          next    = line_dirty ? WRITE_BACK : MEM_READ;
        end
      end
      WRITE_BACK: begin
        mem_write = 1'b1;
        if (done) begin
          next    = MEM_READ;
          entry_d = 1'b1;
        end
      end
      MEM_READ: begin
        mem_read = 1'b1;
        if (done) begin
          fill = 1'b1;
          next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back write-allocate byte cache over a
// 32-bit block memory. Ports: clk, rst (sync, active high),
// CPU read/write/address/writedata/readdata/busywait, memory
// mem_read/mem_write/mem_address/mem_writedata/mem_readdata/
// mem_busywait. `define DATA_CACHE_STATS_EN adds hit_count and
// miss_count (16-bit, saturating).
module data_cache
  import data_cache_pkg::*;
#(
  parameter int INDEX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busywait,
  input  logic                  mem_busywait,
  input  logic                  write,
  output logic                  mem_write,
  input  logic                  read,
  output logic                  mem_read,
  input  logic [7:0]            writedata,
  output logic [BLOCK_W-1:0]    mem_writedata,
  output logic [7:0]            readdata,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  input  logic [ADDR_W-1:0]     address,
  output logic [MEM_ADDR_W-1:0] mem_address
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = MEM_ADDR_W - INDEX_W;

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  logic [1:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               wr_hit;
  logic               fill;
  logic               miss;
  state_t             state;

  // the missing request is latched so a dropped or changed
  // CPU address cannot redirect a fill already in flight
  logic [INDEX_W-1:0] req_idx_q;
  logic [TAG_W-1:0]   req_tag_q;

  assign offset = address[1:0];
  assign index  = address[INDEX_W+1:2];
  assign tag    = address[ADDR_W-1:INDEX_W+2];
  assign hit    = valid_q[index] && (tag_q[index] == tag);
  assign wr_hit = (state == IDLE) && write && hit;

  data_cache_fsm u_fsm (
    .clk          (clk),
    .rst          (rst),
    .read         (read),
    .write        (write),
    .hit          (hit),
    .line_dirty   (valid_q[index] && dirty_q[index]),
    .mem_busywait (mem_busywait),
    .state        (state),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .fill         (fill),
    .miss         (miss)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[req_idx_q] <= 1'b1;
      dirty_q[req_idx_q] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (miss) begin
      req_idx_q <= index;
      req_tag_q <= tag;
    end
    if (fill) begin
      data_q[req_idx_q] <= mem_readdata;
      tag_q[req_idx_q]  <= req_tag_q;
    end else if (wr_hit) begin
      data_q[index][{offset, 3'b000} +: 8] <= writedata;
    end
  end

  always_comb begin
    readdata = 8'h00;
    if (state == IDLE && read && hit)
      readdata = data_q[index][{offset, 3'b000} +: 8];
  end

  always_comb begin
    mem_address   = '0;
    mem_writedata = '0;
    unique case (state)
      WRITE_BACK: begin
        mem_address   = {tag_q[req_idx_q], req_idx_q};
        mem_writedata = data_q[req_idx_q];
      end
      MEM_READ: mem_address = {req_tag_q, req_idx_q};
      default: ;
    endcase
  end

`ifdef DATA_CACHE_STATS_EN
  // the IDLE completion right after a fill is not a first-lookup hit
  logic after_fill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      after_fill_q <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      after_fill_q <= fill;
      if (state == IDLE && (read || write) && hit &&
          !after_fill_q && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (miss && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: fills, write hits,
// write-back, long memory latency, reset mid-fill, stats.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        busywait;
  logic        mem_busywait;
  logic        write;
  logic        mem_write;
  logic        read;
  logic        mem_read;
  logic [7:0]  writedata;
  logic [31:0] mem_writedata;
  logic [7:0]  readdata;
  logic [31:0] mem_readdata;
  logic [7:0]  address;
  logic [5:0]  mem_address;
`ifdef DATA_CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  data_cache dut (
    .clk           (clk),
    .rst           (rst),
    .busywait      (busywait),
    .mem_busywait  (mem_busywait),
    .write         (write),
    .mem_write     (mem_write),
    .read          (read),
    .mem_read      (mem_read),
    .writedata     (writedata),
    .mem_writedata (mem_writedata),
    .readdata      (readdata),
    .mem_readdata  (mem_readdata),
    .address       (address),
    .mem_address   (mem_address)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // called in the cycle a memory state is entered; busywait
  // stays low through the entry edge, then high for lat cycles
  task automatic mem_phase(input string tag,
                           input logic rd,
                           input logic [5:0] addr,
                           input logic [31:0] wdata,
                           input int lat,
                           input logic [31:0] rdata);
    check({tag, " mem_read"}, 32'(mem_read), 32'(rd));
    check({tag, " mem_write"}, 32'(mem_write), 32'(!rd));
    check({tag, " mem_address"}, 32'(mem_address), 32'(addr));
    if (!rd) check({tag, " mem_writedata"}, mem_writedata, wdata);
    check({tag, " busywait"}, 32'(busywait), 32'd1);
    tick();
    check({tag, " entry held"}, {30'd0, mem_read, mem_write},
          {30'd0, rd, !rd});
    mem_busywait = 1'b1;
    mem_readdata = 32'hDEADBEEF;
    for (int i = 0; i < lat; i++) begin
      tick();
      check({tag, " busy held"},
            {29'd0, mem_read, mem_write, busywait},
            {29'd0, rd, !rd, 1'b1});
    end
    mem_busywait = 1'b0;
    mem_readdata = rdata;
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    read         = 1'b0;
    write        = 1'b0;
    writedata    = 8'h00;
    address      = 8'h00;
    mem_busywait = 1'b0;
    mem_readdata = 32'h0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst busywait", 32'(busywait), 32'd0);
    check("rst mem_read", 32'(mem_read), 32'd0);
    check("rst mem_write", 32'(mem_write), 32'd0);
    check("rst mem_address", 32'(mem_address), 32'd0);
    check("rst readdata", 32'(readdata), 32'd0);

    // cold read miss on 0x00
    read = 1'b1;
    address = 8'h00;
    #1;
    check("miss0 busywait", 32'(busywait), 32'd1);
    tick();
    mem_phase("fill0", 1'b1, 6'h00, 32'h0, 1, 32'h44332211);
    check("fill0 busywait", 32'(busywait), 32'd0);
    check("fill0 readdata", 32'(readdata), 32'h11);
    tick();
    read = 1'b0;

    // write hit then read back
    write = 1'b1;
    address = 8'h01;
    writedata = 8'h23;
    #1;
    check("wrhit busywait", 32'(busywait), 32'd0);
    tick();
    write = 1'b0;
    read = 1'b1;
    #1;
    check("rdhit busywait", 32'(busywait), 32'd0);
    check("rdhit readdata", 32'(readdata), 32'h23);
    tick();
    read = 1'b0;

    // dirty conflict: write-back then fill
    write = 1'b1;
    address = 8'h20;
    writedata = 8'h09;
    #1;
    check("conf busywait", 32'(busywait), 32'd1);
    tick();
    mem_phase("wb0", 1'b0, 6'h00, 32'h44332311, 2, 32'h0);
    mem_phase("fill8", 1'b1, 6'h08, 32'h0, 1, 32'hAABBCCDD);
    check("conf wr busywait", 32'(busywait), 32'd0);
    tick();
    write = 1'b0;
    read = 1'b1;
    #1;
    check("rd 0x20", 32'(readdata), 32'h09);
    address = 8'h23;
    #1;
    check("rd 0x23", 32'(readdata), 32'hAA);
    tick();

    // long memory latency, garbage data while busy
    address = 8'h44;
    #1;
    check("lat busywait", 32'(busywait), 32'd1);
    tick();
    mem_phase("lat5", 1'b1, 6'h11, 32'h0, 5, 32'h87654321);
    check("lat readdata", 32'(readdata), 32'h21);
    check("lat busywait low", 32'(busywait), 32'd0);
    tick();

    // reset in the middle of MEM_READ
    address = 8'h48;
    tick();
    check("rstmr mem_read", 32'(mem_read), 32'd1);
    tick();
    mem_busywait = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_busywait = 1'b0;
    check("rstmr mem_read off", 32'(mem_read), 32'd0);
    check("rstmr mem_address", 32'(mem_address), 32'd0);
    check("rstmr busywait", 32'(busywait), 32'd1);
    tick();
    mem_phase("refill", 1'b1, 6'h12, 32'h0, 1, 32'h0C0B0A09);
    check("refill readdata", 32'(readdata), 32'h09);
    tick();
    address = 8'h44;
    #1;
    check("inval busywait", 32'(busywait), 32'd1);
    tick();
    mem_phase("refill44", 1'b1, 6'h11, 32'h0, 0, 32'h87654321);
    check("refill44 readdata", 32'(readdata), 32'h21);
    tick();
    read = 1'b0;

`ifdef DATA_CACHE_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stats rst hits", 32'(hit_count), 32'd0);
    read = 1'b1;
    address = 8'h00;
    tick();
    mem_phase("stfill", 1'b1, 6'h00, 32'h0, 1, 32'h44332211);
    tick();
    for (int i = 1; i < 4; i++) begin
      address = 8'(i);
      tick();
    end
    read = 1'b0;
    #1;
    check("stats miss", 32'(miss_count), 32'd1);
    check("stats hit", 32'(hit_count), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
